// File: rtl/munoc_apb_multi_initiator_arbiter_pkg.sv
// Shared definitions for the multi-initiator APB arbiter and its picker.
package munoc_apb_arb_pkg;

    // Arbiter FSM encoding; IDLE must stay at zero so a reset register reads IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    // Arbitration mode codes.
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of the ACCESS-phase timeout counter (limit is at most 65535).
    localparam int BW_TIMEOUT = 16;

    // Width of a grant index for a given number of initiators.
    function automatic int grant_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/munoc_apb_multi_initiator_arbiter_if.sv
// Bundle of all initiator-side and target-side APB signals of the arbiter.
//
// Handshake: an initiator requests by holding psel and penable high (its
// ACCESS phase); the arbiter finishes that request in the single cycle where
// that initiator's rpready bit is high, and rprdata/rpslverr are valid only
// in that cycle. Towards the target the arbiter runs a plain APB SETUP
// (spsel=1, spenable=0) followed by ACCESS (spsel=1, spenable=1) held until
// spready or timeout; the target's response is taken in the spready cycle.
//
// master: the arbiter's view. slave: the surrounding environment's view.
interface munoc_apb_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int BW_ADDR = 32,
    parameter int BW_DATA = 32
);
    import munoc_apb_arb_pkg::*;

    localparam int BW_STRB  = BW_DATA / 8;
    localparam int BW_GRANT = grant_width(NUM_REQ);

    // Initiator side
    logic [NUM_REQ-1:0]         rpsel;
    logic [NUM_REQ-1:0]         rpenable;
    logic [NUM_REQ*BW_ADDR-1:0] rpaddr;
    logic [NUM_REQ-1:0]         rpwrite;
    logic [NUM_REQ*BW_DATA-1:0] rpwdata;
    logic [NUM_REQ*BW_STRB-1:0] rpwstrb;
    logic [BW_DATA-1:0]         rprdata;
    logic [NUM_REQ-1:0]         rpready;
    logic [NUM_REQ-1:0]         rpslverr;

    // Target side
    logic                       spsel;
    logic                       spenable;
    logic [BW_ADDR-1:0]         spaddr;
    logic                       spwrite;
    logic [BW_DATA-1:0]         spwdata;
    logic [BW_STRB-1:0]         spwstrb;
    logic [BW_DATA-1:0]         sprdata;
    logic                       spready;
    logic                       spslverr;

    // Status
    logic [BW_GRANT-1:0]        sgrant_id;
    logic                       timeout_event;
    arb_state_e                 dbg_state;

    modport master (
        input  rpsel, rpenable, rpaddr, rpwrite, rpwdata, rpwstrb,
        output rprdata, rpready, rpslverr,
        output spsel, spenable, spaddr, spwrite, spwdata, spwstrb,
        input  sprdata, spready, spslverr,
        output sgrant_id, timeout_event, dbg_state
    );

    modport slave (
        output rpsel, rpenable, rpaddr, rpwrite, rpwdata, rpwstrb,
        input  rprdata, rpready, rpslverr,
        input  spsel, spenable, spaddr, spwrite, spwdata, spwstrb,
        output sprdata, spready, spslverr,
        input  sgrant_id, timeout_event, dbg_state
    );

endinterface

// File: rtl/munoc_apb_multi_initiator_arbiter_picker.sv
// Rotating priority encoder: returns the first requesting index at or above
// ptr_i (wrapping at NUM_REQ), or the lowest requesting index when mode_i=1.
module munoc_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int BW_IDX  = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [BW_IDX-1:0]  ptr_i,
    input  logic               mode_i,
    output logic               found_o,
    output logic [BW_IDX-1:0]  idx_o
);
    // One spare bit so ptr + offset cannot overflow before the wrap.
    localparam int BW_W = BW_IDX + 1;

    logic [BW_W-1:0]   cand;
    logic [BW_IDX-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest requester is the last one written.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        cand     = '0;
        cand_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = mode_i ? BW_W'(k) : ({1'b0, ptr_i} + BW_W'(k));
            if (cand >= BW_W'(NUM_REQ)) begin
                cand = cand - BW_W'(NUM_REQ);
            end
            cand_idx = cand[BW_IDX-1:0];
            if (req_i[cand_idx]) begin
                found_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/munoc_apb_multi_initiator_arbiter.sv
// N-initiator APB arbiter: merges several APB requesters onto one APB target
// with round-robin or fixed-priority selection, a full SETUP/ACCESS sequence
// towards the target and an optional ACCESS timeout that answers SLVERR.
module munoc_apb_multi_initiator_arbiter
    import munoc_apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int BW_ADDR        = 32,
    parameter int BW_DATA        = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rstnn,
    munoc_apb_arb_if.master bus
);
    localparam int BW_STRB  = BW_DATA / 8;
    localparam int BW_GRANT = grant_width(NUM_REQ);

    localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);
    localparam logic TO_EN      = (TIMEOUT_CYCLES > 0);
    localparam logic [BW_TIMEOUT-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? BW_TIMEOUT'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e            state_q;
    logic [BW_GRANT-1:0]   gnt_q;
    logic [BW_GRANT-1:0]   rr_ptr_q;
    logic [BW_TIMEOUT-1:0] cnt_q;
    logic                  spsel_q;
    logic                  spenable_q;
    logic [BW_ADDR-1:0]    spaddr_q;
    logic                  spwrite_q;
    logic [BW_DATA-1:0]    spwdata_q;
    logic [BW_STRB-1:0]    spwstrb_q;

    logic [NUM_REQ-1:0]    pending;
    logic                  pick_found;
    logic [BW_GRANT-1:0]   pick_idx;
    logic [BW_GRANT-1:0]   gnt_next;
    logic                  timeout_hit;
    logic                  xfer_done;

    logic [NUM_REQ-1:0]    rpready_c;
    logic [NUM_REQ-1:0]    rpslverr_c;
    logic [BW_DATA-1:0]    rprdata_c;

    logic [BW_ADDR-1:0]    req_addr  [NUM_REQ];
    logic [BW_DATA-1:0]    req_wdata [NUM_REQ];
    logic [BW_STRB-1:0]    req_wstrb [NUM_REQ];

    // Split the packed initiator buses into per-initiator words.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr[i]  = bus.rpaddr[i*BW_ADDR +: BW_ADDR];
        assign req_wdata[i] = bus.rpwdata[i*BW_DATA +: BW_DATA];
        assign req_wstrb[i] = bus.rpwstrb[i*BW_STRB +: BW_STRB];
    end

    // An initiator competes only once it is in its own ACCESS phase.
    assign pending = bus.rpsel & bus.rpenable;

    munoc_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .BW_IDX  (BW_GRANT)
    ) u_picker (
        .req_i   (pending),
        .ptr_i   (rr_ptr_q),
        .mode_i  (FIXED_MODE),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // A target answer on the limit cycle wins over the timeout.
    assign timeout_hit = TO_EN && (state_q == ST_ACCESS) &&
                         (cnt_q == TO_LAST) && !bus.spready;
    assign xfer_done   = (state_q == ST_ACCESS) && (bus.spready || timeout_hit);
    assign gnt_next    = (gnt_q == BW_GRANT'(NUM_REQ - 1)) ? '0 : gnt_q + BW_GRANT'(1);

    // Transfer sequencer: grant and capture in IDLE, SETUP for one cycle, ACCESS until done.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            spsel_q    <= 1'b0;
            spenable_q <= 1'b0;
            spaddr_q   <= '0;
            spwrite_q  <= 1'b0;
            spwdata_q  <= '0;
            spwstrb_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q    <= ST_SETUP;
                        gnt_q      <= pick_idx;
                        spsel_q    <= 1'b1;
                        spenable_q <= 1'b0;
                        spaddr_q   <= req_addr[pick_idx];
                        spwrite_q  <= bus.rpwrite[pick_idx];
                        spwdata_q  <= req_wdata[pick_idx];
                        spwstrb_q  <= req_wstrb[pick_idx];
                    end
                end
                ST_SETUP: begin
                    state_q    <= ST_ACCESS;
                    spenable_q <= 1'b1;
                    cnt_q      <= '0;
                end
                ST_ACCESS: begin
                    if (xfer_done) begin
                        state_q    <= ST_IDLE;
                        spsel_q    <= 1'b0;
                        spenable_q <= 1'b0;
                        if (!FIXED_MODE) begin
                            rr_ptr_q <= gnt_next;
                        end
                    end else if (TO_EN) begin
                        cnt_q <= cnt_q + BW_TIMEOUT'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    spsel_q    <= 1'b0;
                    spenable_q <= 1'b0;
                end
            endcase
        end
    end

    // Route the target response (or the timeout error) back to the owner only.
    always_comb begin
        rpready_c  = '0;
        rpslverr_c = '0;
        rprdata_c  = '0;
        if (state_q == ST_ACCESS) begin
            rpready_c[gnt_q]  = bus.spready || timeout_hit;
            rpslverr_c[gnt_q] = timeout_hit ? 1'b1 : bus.spslverr;
            rprdata_c         = timeout_hit ? '0 : bus.sprdata;
        end
    end

    assign bus.rpready       = rpready_c;
    assign bus.rpslverr      = rpslverr_c;
    assign bus.rprdata       = rprdata_c;
    assign bus.spsel         = spsel_q;
    assign bus.spenable      = spenable_q;
    assign bus.spaddr        = spaddr_q;
    assign bus.spwrite       = spwrite_q;
    assign bus.spwdata       = spwdata_q;
    assign bus.spwstrb       = spwstrb_q;
    assign bus.sgrant_id     = gnt_q;
    assign bus.timeout_event = timeout_hit;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_munoc_apb_multi_initiator_arbiter.sv
// Bench for the multi-initiator APB arbiter: a round-robin instance with a
// 4-cycle timeout and a fixed-priority instance, both with three initiators.
module tb_munoc_apb_multi_initiator_arbiter;
    import munoc_apb_arb_pkg::*;

    localparam int NR = 3;
    localparam int BA = 32;
    localparam int BD = 32;
    localparam int BS = BD / 8;
    // expected entry: {grant[1:0], rpready[2:0], rpslverr[2:0], rprdata[31:0], timeout_event}
    localparam int EW = 2 + 3 + 3 + 32 + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    munoc_apb_arb_if #(.NUM_REQ(NR), .BW_ADDR(BA), .BW_DATA(BD)) bus_a ();
    munoc_apb_arb_if #(.NUM_REQ(NR), .BW_ADDR(BA), .BW_DATA(BD)) bus_b ();

    munoc_apb_multi_initiator_arbiter #(
        .NUM_REQ(NR), .BW_ADDR(BA), .BW_DATA(BD), .ARB_MODE(0), .TIMEOUT_CYCLES(4)
    ) u_dut_a (
        .clk   (clk),
        .rstnn (rst_n),
        .bus   (bus_a)
    );

    munoc_apb_multi_initiator_arbiter #(
        .NUM_REQ(NR), .BW_ADDR(BA), .BW_DATA(BD), .ARB_MODE(1), .TIMEOUT_CYCLES(0)
    ) u_dut_b (
        .clk   (clk),
        .rstnn (rst_n),
        .bus   (bus_b)
    );

    // ---------------- target models ----------------
    int          wait_a = 0, wait_b = 0, acc_a = 0, acc_b = 0;
    logic        hang_a = 1'b0, hang_b = 1'b0, err_a = 1'b0, err_b = 1'b0;
    logic [31:0] rdata_a = 32'h0, rdata_b = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_a <= 0;
        else if (bus_a.spsel && bus_a.spenable && !bus_a.spready) acc_a <= acc_a + 1;
        else acc_a <= 0;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_b <= 0;
        else if (bus_b.spsel && bus_b.spenable && !bus_b.spready) acc_b <= acc_b + 1;
        else acc_b <= 0;
    end

    assign bus_a.spready  = bus_a.spsel && bus_a.spenable && !hang_a && (acc_a == wait_a);
    assign bus_a.spslverr = bus_a.spready && err_a;
    assign bus_a.sprdata  = rdata_a;
    assign bus_b.spready  = bus_b.spsel && bus_b.spenable && !hang_b && (acc_b == wait_b);
    assign bus_b.spslverr = bus_b.spready && err_b;
    assign bus_b.sprdata  = rdata_b;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;
    int done_a = 0;
    int done_b = 0;
    logic [EW-1:0] exp_a[$];
    logic [EW-1:0] exp_b[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_exp(input int idx, input logic err,
                                             input logic [31:0] rd, input logic tev);
        logic [2:0] oh;
        oh = 3'(1 << idx);
        return {2'(idx), oh, (err ? oh : 3'b000), rd, tev};
    endfunction

    // Scoreboard for instance A: every rpready cycle consumes one expected entry.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && bus_a.rpready != '0) begin
            if (exp_a.size() == 0) begin
                check_eq("a_unexpected_rpready", 64'(bus_a.rpready), 64'd0);
            end else begin
                e = exp_a.pop_front();
                check_eq("a_grant",    64'(bus_a.sgrant_id),     64'(e[40:39]));
                check_eq("a_rpready",  64'(bus_a.rpready),       64'(e[38:36]));
                check_eq("a_rpslverr", 64'(bus_a.rpslverr),      64'(e[35:33]));
                check_eq("a_rprdata",  64'(bus_a.rprdata),       64'(e[32:1]));
                check_eq("a_tevent",   64'(bus_a.timeout_event), 64'(e[0]));
                done_a++;
            end
        end else if (rst_n && bus_a.timeout_event) begin
            check_eq("a_stray_tevent", 64'(bus_a.timeout_event), 64'd0);
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && bus_b.rpready != '0) begin
            if (exp_b.size() == 0) begin
                check_eq("b_unexpected_rpready", 64'(bus_b.rpready), 64'd0);
            end else begin
                e = exp_b.pop_front();
                check_eq("b_grant",    64'(bus_b.sgrant_id), 64'(e[40:39]));
                check_eq("b_rpready",  64'(bus_b.rpready),   64'(e[38:36]));
                check_eq("b_rpslverr", 64'(bus_b.rpslverr),  64'(e[35:33]));
                check_eq("b_rprdata",  64'(bus_b.rprdata),   64'(e[32:1]));
                done_b++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit on_b, input int i, input logic on,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
        if (on_b) begin
            bus_b.rpsel[i]             = on;
            bus_b.rpenable[i]          = on;
            bus_b.rpaddr[i*BA +: BA]   = addr;
            bus_b.rpwdata[i*BD +: BD]  = wdata;
            bus_b.rpwstrb[i*BS +: BS]  = 4'hF;
            bus_b.rpwrite[i]           = wr;
        end else begin
            bus_a.rpsel[i]             = on;
            bus_a.rpenable[i]          = on;
            bus_a.rpaddr[i*BA +: BA]   = addr;
            bus_a.rpwdata[i*BD +: BD]  = wdata;
            bus_a.rpwstrb[i*BS +: BS]  = 4'hF;
            bus_a.rpwrite[i]           = wr;
        end
    endtask

    task automatic wait_done(input bit on_b, input int target);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if ((on_b ? done_b : done_a) >= target) break;
        end
        check_eq(on_b ? "b_wait_done" : "a_wait_done",
                 64'(on_b ? done_b : done_a), 64'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start;
        bus_a.rpsel = '0; bus_a.rpenable = '0; bus_a.rpaddr = '0;
        bus_a.rpwrite = '0; bus_a.rpwdata = '0; bus_a.rpwstrb = '0;
        bus_b.rpsel = '0; bus_b.rpenable = '0; bus_b.rpaddr = '0;
        bus_b.rpwrite = '0; bus_b.rpwdata = '0; bus_b.rpwstrb = '0;
        rst_n = 1'b0;

        // Reset values
        @(negedge clk);
        check_eq("rst_spsel",    64'(bus_a.spsel),         64'd0);
        check_eq("rst_spenable", 64'(bus_a.spenable),      64'd0);
        check_eq("rst_rpready",  64'(bus_a.rpready),       64'd0);
        check_eq("rst_grant",    64'(bus_a.sgrant_id),     64'd0);
        check_eq("rst_tevent",   64'(bus_a.timeout_event), 64'd0);
        check_eq("rst_state",    64'(bus_a.dbg_state),     64'(ST_IDLE));
        check_eq("rst_b_spsel",  64'(bus_b.spsel),         64'd0);
        #2 rst_n = 1'b1;
        repeat (2) next_cycle();

        // Round-robin fairness: all three pending for six transfers
        rdata_a = 32'h0BAD_F00D;
        for (int i = 0; i < NR; i++) drive_req(0, i, 1'b1, 32'h10 * (i + 1), 32'h1000 + i, 1'b1);
        for (int k = 0; k < 6; k++) exp_a.push_back(mk_exp(k % 3, 1'b0, rdata_a, 1'b0));
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check_eq("rr_spsel",    64'(bus_a.spsel),    64'(k % 3 != 0));
            check_eq("rr_spenable", 64'(bus_a.spenable), 64'(k % 3 == 2));
            if (k % 3 == 1) check_eq("rr_grant", 64'(bus_a.sgrant_id), 64'((k / 3) % 3));
        end
        next_cycle();
        for (int i = 0; i < NR; i++) drive_req(0, i, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("rr_idle_after", 64'(bus_a.spsel), 64'd0);
        repeat (2) next_cycle();

        // Single request with latency and capture checks
        rdata_a = 32'h1234_5678;
        drive_req(0, 1, 1'b1, 32'h100, 32'hA5A5_0001, 1'b1);
        exp_a.push_back(mk_exp(1, 1'b0, rdata_a, 1'b0));
        @(negedge clk);
        check_eq("single_c0_spsel", 64'(bus_a.spsel), 64'd0);
        @(negedge clk);
        check_eq("single_c1_spsel",    64'(bus_a.spsel),     64'd1);
        check_eq("single_c1_spenable", 64'(bus_a.spenable),  64'd0);
        check_eq("single_c1_grant",    64'(bus_a.sgrant_id), 64'd1);
        check_eq("single_c1_spaddr",   64'(bus_a.spaddr),    64'h100);
        check_eq("single_c1_spwdata",  64'(bus_a.spwdata),   64'hA5A5_0001);
        check_eq("single_c1_spwrite",  64'(bus_a.spwrite),   64'd1);
        check_eq("single_c1_spwstrb",  64'(bus_a.spwstrb),   64'hF);
        next_cycle();
        drive_req(0, 1, 1'b1, 32'h200, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("single_c2_spenable", 64'(bus_a.spenable), 64'd1);
        check_eq("single_c2_spaddr",   64'(bus_a.spaddr),   64'h100);
        check_eq("single_c2_rpready",  64'(bus_a.rpready),  64'b010);
        next_cycle();
        drive_req(0, 1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("single_c3_spsel", 64'(bus_a.spsel), 64'd0);
        repeat (2) next_cycle();

        // Wait states and slave error; 3 waits land on the timeout limit cycle
        wait_a = 3; err_a = 1'b1; rdata_a = 32'hDEAD_BEEF;
        start = done_a;
        drive_req(0, 0, 1'b1, 32'h300, 32'h3, 1'b0);
        drive_req(0, 2, 1'b1, 32'h320, 32'h5, 1'b0);
        exp_a.push_back(mk_exp(2, 1'b1, rdata_a, 1'b0));
        exp_a.push_back(mk_exp(0, 1'b1, rdata_a, 1'b0));
        wait_done(0, start + 2);
        next_cycle();
        drive_req(0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_req(0, 2, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) next_cycle();

        // Timeout: target never answers
        wait_a = 0; err_a = 1'b0; hang_a = 1'b1; rdata_a = 32'h5555_AAAA;
        drive_req(0, 1, 1'b1, 32'h400, 32'h7, 1'b0);
        exp_a.push_back(mk_exp(1, 1'b1, 32'h0, 1'b1));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("to_tevent", 64'(bus_a.timeout_event), 64'(k == 5));
            if (k >= 2) check_eq("to_spenable", 64'(bus_a.spenable), 64'd1);
        end
        next_cycle();
        drive_req(0, 1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("to_after_spsel",  64'(bus_a.spsel),         64'd0);
        check_eq("to_after_tevent", 64'(bus_a.timeout_event), 64'd0);
        repeat (2) next_cycle();

        // Reset in the middle of ACCESS
        drive_req(0, 2, 1'b1, 32'h500, 32'h9, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("rstmid_in_access", 64'(bus_a.dbg_state), 64'(ST_ACCESS));
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_spsel",    64'(bus_a.spsel),         64'd0);
        check_eq("rstmid_spenable", 64'(bus_a.spenable),      64'd0);
        check_eq("rstmid_rpready",  64'(bus_a.rpready),       64'd0);
        check_eq("rstmid_rpslverr", 64'(bus_a.rpslverr),      64'd0);
        check_eq("rstmid_grant",    64'(bus_a.sgrant_id),     64'd0);
        check_eq("rstmid_spaddr",   64'(bus_a.spaddr),        64'd0);
        check_eq("rstmid_tevent",   64'(bus_a.timeout_event), 64'd0);
        hang_a = 1'b0; rdata_a = 32'h0000_C0DE;
        drive_req(0, 0, 1'b1, 32'h600, 32'hB, 1'b1);
        exp_a.push_back(mk_exp(0, 1'b0, rdata_a, 1'b0));
        exp_a.push_back(mk_exp(2, 1'b0, rdata_a, 1'b0));
        start = done_a;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_done(0, start + 2);
        next_cycle();
        drive_req(0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_req(0, 2, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) next_cycle();

        // Fixed priority on instance B: 0 always beats 2 until it withdraws
        rdata_b = 32'h00FE_ED00 + $urandom_range(0, 255);
        start = done_b;
        drive_req(1, 0, 1'b1, 32'h700, 32'h1, 1'b1);
        drive_req(1, 2, 1'b1, 32'h720, 32'h2, 1'b1);
        for (int k = 0; k < 3; k++) exp_b.push_back(mk_exp(0, 1'b0, rdata_b, 1'b0));
        wait_done(1, start + 3);
        next_cycle();
        drive_req(1, 0, 1'b0, 32'h0, 32'h0, 1'b0);
        exp_b.push_back(mk_exp(2, 1'b0, rdata_b, 1'b0));
        wait_done(1, start + 4);
        next_cycle();
        drive_req(1, 2, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) next_cycle();

        // Final report
        check_eq("a_leftover", 64'(exp_a.size()), 64'd0);
        check_eq("b_leftover", 64'(exp_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
